// File: rtl/ntt_basemul.sv
// ntt_basemul: Kyber pointwise NTT-domain multiply (q=3329), one pair per cycle, 3-stage pipeline.
// Define NTT_BASEMUL_CENTERED_EN for centered outputs in [-(Q-1)/2, (Q-1)/2].
module ntt_basemul #(
  parameter int DATA_W = 16,
  parameter int Q = 3329
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] f_hat [256],
  input  logic signed [DATA_W-1:0] g_hat [256],
  output logic signed [DATA_W-1:0] h_hat [256],
  output logic                     done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  function automatic int brv7(input int k);
    int r = 0;
    for (int i = 0; i < 7; i++) r = r | (((k >> i) & 1) << (6 - i));
    return r;
  endfunction
  function automatic int zpow(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = (r * 17) % Q;
    return r;
  endfunction
  function automatic logic [11:0] modq(input logic signed [31:0] x);
    logic signed [31:0] r;
    r = x % Q;
    return 12'(r < 0 ? r + Q : r);
  endfunction
  function automatic logic signed [DATA_W-1:0] fmt(input logic [11:0] v);
`ifdef NTT_BASEMUL_CENTERED_EN
    return v > 12'(Q / 2) ? DATA_W'(v) - DATA_W'(Q) : DATA_W'(v);
`else
    return DATA_W'(v);
`endif
  endfunction
  logic [11:0] rom [128];
  for (genvar i = 0; i < 128; i++) begin : g_rom
    localparam int G = zpow(2 * brv7(i) + 1);
    assign rom[i] = 12'(G);
  end
  state_t state, nxt;
  logic [6:0] idx, k1, k2;
  logic v1, v2;
  logic signed [25:0] a0, a1, b0, b1, p00, p11, p01, p10, q00, s1, m;
  logic [11:0] r11, c0, c1;
  assign a0 = 26'(f_hat[{idx, 1'b0}]);
  assign a1 = 26'(f_hat[{idx, 1'b1}]);
  assign b0 = 26'(g_hat[{idx, 1'b0}]);
  assign b1 = 26'(g_hat[{idx, 1'b1}]);
  // r11 and gamma are both below Q, so their product fits the 26-bit signed range
  assign m  = signed'(26'(r11)) * signed'(26'(rom[k2]));
  assign c0 = modq(32'(q00) + 32'(m));
  assign c1 = modq(32'(s1));
  assign done = state == DONE;
  always_ff @(posedge clk) state <= !reset ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: nxt = start ? RUN : state;
      RUN:        nxt = idx == 7'd127 ? DRAIN : RUN;
      DRAIN:      nxt = (v2 && k2 == 7'd127) ? DONE : DRAIN;
      default:    nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      for (int i = 0; i < 256; i++) h_hat[i] <= '0;
    end else begin
      idx <= state == RUN ? idx + 7'd1 : 7'd0;
      v1 <= state == RUN;
      k1 <= idx;
      p00 <= a0 * b0;
      p11 <= a1 * b1;
      p01 <= a0 * b1;
      p10 <= a1 * b0;
      v2 <= v1;
      k2 <= k1;
      q00 <= p00;
      r11 <= modq(32'(p11));
      s1 <= p01 + p10;
      if (v2) begin
        h_hat[{k2, 1'b0}] <= fmt(c0);
        h_hat[{k2, 1'b1}] <= fmt(c1);
      end
    end
  end
endmodule

// File: tb/tb_ntt_basemul.sv
// tb_ntt_basemul: directed and random checks of ntt_basemul against an arithmetic reference model.
module tb_ntt_basemul;
  localparam int Q = 3329;
  logic clk = 0, reset = 0, start = 0;
  logic signed [15:0] f_hat [256], g_hat [256], h_hat [256];
  logic done;
  int n_vec = 0, n_bad = 0;
  int exp_h [256];
  ntt_basemul dut (.clk(clk), .reset(reset), .start(start), .f_hat(f_hat), .g_hat(g_hat),
                   .h_hat(h_hat), .done(done));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  task automatic check(input string tag, input int got, input int want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask
  function automatic int md(input longint x);
    longint r = x % Q;
    return int'(r < 0 ? r + Q : r);
  endfunction
  function automatic int gam(input int k);
    int e = 0, r = 1;
    for (int i = 0; i < 7; i++) if (k[i]) e += 1 << (6 - i);
    e = 2 * e + 1;
    for (int i = 0; i < e; i++) r = r * 17 % Q;
    return r;
  endfunction
  function automatic int fmt(input int v);
`ifdef NTT_BASEMUL_CENTERED_EN
    return v > (Q - 1) / 2 ? v - Q : v;
`else
    return v;
`endif
  endfunction
  task automatic model();
    for (int k = 0; k < 128; k++) begin
      longint a0 = f_hat[2*k], a1 = f_hat[2*k+1], b0 = g_hat[2*k], b1 = g_hat[2*k+1];
      exp_h[2*k]   = fmt(md(a0 * b0 + a1 * b1 * gam(k)));
      exp_h[2*k+1] = fmt(md(a0 * b1 + a1 * b0));
    end
  endtask
  task automatic check_h(input string tag);
    for (int i = 0; i < 256; i++) check($sformatf("%s h[%0d]", tag, i), int'(h_hat[i]), exp_h[i]);
  endtask
  task automatic clear();
    for (int i = 0; i < 256; i++) begin
      f_hat[i] = 0;
      g_hat[i] = 0;
    end
  endtask
  task automatic rnd();
    for (int i = 0; i < 256; i++) begin
      f_hat[i] = 16'($urandom_range(0, 2 * Q - 2) - (Q - 1));
      g_hat[i] = 16'($urandom_range(0, 2 * Q - 2) - (Q - 1));
    end
  endtask
  task automatic run(input string tag, input int hold, input int repulse);
    int cyc;
    model();
    start = 1;
    repeat (hold) @(posedge clk);
    #1 start = 0;
    cyc = hold - 1;
    check({tag, " busy"}, done, 0);
    while (!done && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
      start = cyc == repulse;
    end
    start = 0;
    check({tag, " latency"}, cyc, 130);
    check_h(tag);
  endtask
  initial begin
    clear();
    repeat (3) @(posedge clk);
    #1 check("reset done", done, 0);
    for (int i = 0; i < 256; i++) exp_h[i] = 0;
    check_h("reset");
    reset = 1;
    @(posedge clk);
    #1 run("zero", 1, -1);
    f_hat[0] = 1;
    g_hat[0] = 1;
    run("unit", 1, -1);
    check("unit h0", h_hat[0], 1);
    clear();
    f_hat[1] = 1; g_hat[1] = 1; f_hat[3] = 1; g_hat[3] = 1;
    run("gamma", 1, -1);
    check("gamma0", h_hat[0], 17);
    check("gamma1", h_hat[2], fmt(3312));
    clear();
    f_hat[0] = 3328; f_hat[1] = 3328; g_hat[0] = 3328; g_hat[1] = 3328;
    run("max", 1, -1);
    check("max h0", h_hat[0], 18);
    check("max h1", h_hat[1], 2);
    clear();
    f_hat[0] = -1; g_hat[0] = 3328;
    run("neg", 1, -1);
    check("neg h0", h_hat[0], 1);
    rnd();
    start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (50) @(posedge clk);
    #1 reset = 0;
    @(posedge clk);
    #1 reset = 1;
    check("abort done", done, 0);
    for (int i = 0; i < 256; i++) exp_h[i] = 0;
    check_h("abort");
    repeat (140) @(posedge clk);
    #1 check("abort idle", done, 0);
    run("after abort", 1, -1);
    rnd();
    run("hold2", 2, 60);
    run("restart", 1, -1);
    for (int t = 0; t < 4; t++) begin
      rnd();
      run($sformatf("rand%0d", t), 1, -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
